alu_unit: RTL and testbench

//  Parametrised, handshaked successor to the SAP-1 accumulator ALU.
//  - Accepts an operand pair and an opcode; returns a registered result plus C/Z/N/V flags.
//  - Single-cycle logic/arith ops; optional multi-cycle shift-add multiply.
//  - Sits between the A/B register pair and the bus driver.

---
 rtl/alu_pkg.sv | 38 +++
 rtl/alu_mul_seq.sv | 70 +++++++
 rtl/alu_unit.sv | 190 +++++++++++++++++++
 tb/tb_alu_unit.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared types for the handshaked accumulator ALU.
//            - alu_op_t    : 4-bit opcode encoding
//            - state_t     : sequencer states (idle / multiply in flight)
//            - alu_flags_t : packed C/Z/N/V flag register
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_SHL   = 4'd5,
    OP_SHR   = 4'd6,
    OP_PASSA = 4'd7,
    OP_MUL   = 4'd8
  } alu_op_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  typedef struct packed {
    logic c;
    logic z;
    logic n;
    logic v;
  } alu_flags_t;

endpackage
`default_nettype wire

// File: rtl/alu_mul_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_mul_seq
// Purpose  : Unsigned sequential shift-add multiplier, one partial product
//            per clock.  A start pulse loads the operands; done is high in
//            the cycle where prod holds the full 2*WIDTH-bit product.
// Ports    : clk   in  1          clock, rising edge
//            rst   in  1          asynchronous active-low reset (aborts)
//            start in  1          load a/b and begin
//            a, b  in  WIDTH      multiplicand / multiplier
//            done  out 1          prod valid this cycle
//            prod  out 2*WIDTH    product
// Revision : 1.0 - initial release
// ============================================================================
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   prod
);

  localparam int                c_cnt_w = $clog2(WIDTH + 1);
  localparam logic [c_cnt_w-1:0] c_iters = c_cnt_w'(WIDTH);
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(1);

  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_acc;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_run;
  logic [2*WIDTH-1:0] w_acc_next;

  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

  // The final partial product is added combinationally on the last cycle,
  // so the product is presented exactly WIDTH cycles after start.
  assign done = r_run && (r_cnt == c_last);
  assign prod = w_acc_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_run    <= 1'b0;
    end else if (start) begin
      r_mcand  <= {{WIDTH{1'b0}}, a};
      r_mplier <= b;
      r_acc    <= '0;
      r_cnt    <= c_iters;
      r_run    <= 1'b1;
    end else if (r_run) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt - c_last;
      if (r_cnt == c_last) begin
        r_run <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_unit
// Purpose  : Handshaked accumulator ALU with registered result and C/Z/N/V
//            flags.  Single-cycle logic/arith ops; optional multi-cycle MUL.
// Ports    : clk, rst               clock / async active-low reset
//            in_valid, in_ready     request handshake
//            op[3:0], fi            opcode, flag-update enable
//            a, b [WIDTH]           operands
//            out_valid, out_ready   result handshake
//            out [WIDTH]            registered result
//            carry, zero, neg, ovf  registered flags
//            busy                   multiply in progress
// Revision : 1.0 - initial release
// ============================================================================
module alu_unit #(
  parameter int WIDTH  = 8,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic             fi,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             zero,
  output logic             neg,
  output logic             ovf,
  output logic             busy
);

  import alu_pkg::*;

  localparam int c_shw = $clog2(WIDTH);

  state_t             r_state;
  state_t             w_state_next;
  logic [WIDTH-1:0]   r_out;
  logic               r_out_valid;
  alu_flags_t         r_flags;
  logic               r_mul_fi;

  logic               w_accept;
  logic               w_mul_start;
  logic               w_mul_done;
  logic [2*WIDTH-1:0] w_prod;

  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_diff;
  logic [WIDTH:0]     w_shl;
  logic [WIDTH:0]     w_shr;
  logic [c_shw-1:0]   w_sh;
  logic [WIDTH-1:0]   w_res;
  logic               w_c;
  logic               w_v;
  logic               w_legal;

  function automatic alu_flags_t calc_flags(input logic [WIDTH-1:0] res,
                                            input logic c, input logic v);
    alu_flags_t f;
    f.c = c;
    f.z = (res == '0);
    f.n = res[WIDTH-1];
    f.v = v;
    return f;
  endfunction

  assign in_ready    = rst && (r_state == ST_IDLE) && (!r_out_valid || out_ready);
  assign w_accept    = in_valid && in_ready;
  assign w_mul_start = w_accept && (op == OP_MUL) && MUL_EN;
  assign busy        = (r_state == ST_MUL);

  // Widened datapaths: the extra MSB of sum/diff/shl is carry/borrow/last
  // bit out; for SHR a zero is appended below the LSB to catch the last bit.
  assign w_sh   = b[c_shw-1:0];
  assign w_sum  = {1'b0, a} + {1'b0, b};
  assign w_diff = {1'b0, a} - {1'b0, b};
  assign w_shl  = {1'b0, a} << w_sh;
  assign w_shr  = {a, 1'b0} >> w_sh;

  always_comb begin
    w_res   = '0;
    w_c     = 1'b0;
    w_v     = 1'b0;
    w_legal = 1'b1;
    case (op)
      OP_ADD: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        w_res = w_diff[WIDTH-1:0];
        w_c   = w_diff[WIDTH];
        w_v   = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:   w_res = a & b;
      OP_OR:    w_res = a | b;
      OP_XOR:   w_res = a ^ b;
      OP_SHL: begin
        w_res = w_shl[WIDTH-1:0];
        w_c   = w_shl[WIDTH];
      end
      OP_SHR: begin
        w_res = w_shr[WIDTH:1];
        w_c   = w_shr[0];
      end
      OP_PASSA: w_res = a;
      // MUL takes the sequencer path when present; otherwise it is illegal.
      default:  w_legal = 1'b0;
    endcase
  end

  generate
    if (MUL_EN) begin : g_mul
      alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (w_mul_start),
        .a     (a),
        .b     (b),
        .done  (w_mul_done),
        .prod  (w_prod)
      );
    end else begin : g_no_mul
      assign w_mul_done = 1'b0;
      assign w_prod     = '0;
    end
  endgenerate

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_mul_start) w_state_next = ST_MUL;
      ST_MUL:  if (w_mul_done)  w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_flags     <= '0;
      r_mul_fi    <= 1'b0;
    end else begin
      if (w_mul_start) begin
        r_mul_fi <= fi;
      end
      if (w_accept && !w_mul_start) begin
        r_out       <= w_legal ? w_res : '0;
        r_out_valid <= 1'b1;
        if (w_legal && fi) begin
          r_flags <= calc_flags(w_res, w_c, w_v);
        end
      end else if (w_mul_done) begin
        r_out       <= w_prod[WIDTH-1:0];
        r_out_valid <= 1'b1;
        if (r_mul_fi) begin
          r_flags <= calc_flags(w_prod[WIDTH-1:0], |w_prod[2*WIDTH-1:WIDTH], 1'b0);
        end
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign carry     = r_flags.c;
  assign zero      = r_flags.z;
  assign neg       = r_flags.n;
  assign ovf       = r_flags.v;

endmodule
`default_nettype wire

// File: tb/tb_alu_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_unit
// Purpose  : Self-checking bench for alu_unit (WIDTH=8, MUL_EN=1) using an
//            arithmetic reference model and directed plus random steps.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_unit;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             s_in_valid;
  logic             s_in_ready;
  logic [3:0]       s_op;
  logic             s_fi;
  logic [WIDTH-1:0] s_a;
  logic [WIDTH-1:0] s_b;
  logic             s_out_valid;
  logic             s_out_ready;
  logic [WIDTH-1:0] s_out;
  logic             s_carry;
  logic             s_zero;
  logic             s_neg;
  logic             s_ovf;
  logic             s_busy;

  int checks = 0;
  int errors = 0;

  // Reference state: expected result and flag register contents.
  int e_out = 0;
  bit e_c = 0, e_z = 0, e_n = 0, e_v = 0;

  always #5 clk = ~clk;

  alu_unit #(.WIDTH(WIDTH), .MUL_EN(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s_in_valid),
    .in_ready  (s_in_ready),
    .op        (s_op),
    .fi        (s_fi),
    .a         (s_a),
    .b         (s_b),
    .out_valid (s_out_valid),
    .out_ready (s_out_ready),
    .out       (s_out),
    .carry     (s_carry),
    .zero      (s_zero),
    .neg       (s_neg),
    .ovf       (s_ovf),
    .busy      (s_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Arithmetic model of each opcode on 8-bit unsigned values.
  function automatic void ref_op(input int op, input int a, input int b,
                                 output int res, output bit c, output bit v,
                                 output bit legal);
    int sa, sb, r, s;
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    res = 0; c = 0; v = 0; legal = 1;
    case (op)
      0: begin r = a + b; res = r % 256; c = (r > 255);
               v = (sa + sb > 127) || (sa + sb < -128); end
      1: begin res = (a - b + 256) % 256; c = (a < b);
               v = (sa - sb > 127) || (sa - sb < -128); end
      2: res = a & b;
      3: res = a | b;
      4: res = a ^ b;
      5: begin s = b % 8; res = (a << s) % 256;
               c = (s != 0) && ((((a << s) / 256) % 2) == 1); end
      6: begin s = b % 8; res = a >> s;
               c = (s != 0) && (((a >> (s - 1)) % 2) == 1); end
      7: res = a;
      8: begin r = a * b; res = r % 256; c = (r > 255); end
      default: legal = 0;
    endcase
  endfunction

  task automatic model_update(input int op, input int a, input int b, input bit f);
    int res; bit c, v, legal;
    ref_op(op, a, b, res, c, v, legal);
    e_out = legal ? res : 0;
    if (legal && f) begin
      e_c = c; e_z = (res == 0); e_n = (res >= 128); e_v = v;
    end
  endtask

  task automatic check_result(input string tag);
    chk({tag, ":out"},       s_out,       e_out);
    chk({tag, ":out_valid"}, s_out_valid, 1);
    chk({tag, ":carry"},     s_carry,     e_c);
    chk({tag, ":zero"},      s_zero,      e_z);
    chk({tag, ":neg"},       s_neg,       e_n);
    chk({tag, ":ovf"},       s_ovf,       e_v);
    chk({tag, ":busy"},      s_busy,      0);
  endtask

  // Present one request with out_ready=1, accept it on the next edge and
  // check the result at the cycle it is due.
  task automatic do_op(input int op, input int a, input int b, input bit f, input string tag);
    s_op = op[3:0]; s_a = a[7:0]; s_b = b[7:0]; s_fi = f;
    s_in_valid = 1'b1; s_out_ready = 1'b1;
    chk({tag, ":in_ready"}, s_in_ready, 1);
    step();
    s_in_valid = 1'b0;
    if (op == 8) begin
      for (int i = 0; i < WIDTH; i++) begin
        chk({tag, ":mul_busy"},     s_busy,      1);
        chk({tag, ":mul_in_ready"}, s_in_ready,  0);
        chk({tag, ":mul_out_valid"}, s_out_valid, 0);
        step();
      end
    end
    model_update(op, a, b, f);
    check_result(tag);
  endtask

  initial begin
    int rop;
    rst = 1'b0; s_in_valid = 1'b0; s_op = 4'd0; s_fi = 1'b0;
    s_a = '0; s_b = '0; s_out_ready = 1'b1;

    // Reset state
    step(); step();
    chk("rst:out", s_out, 0);
    chk("rst:out_valid", s_out_valid, 0);
    chk("rst:flags", {s_carry, s_zero, s_neg, s_ovf}, 0);
    chk("rst:busy", s_busy, 0);
    chk("rst:in_ready", s_in_ready, 0);
    rst = 1'b1;
    step();
    chk("post_rst:in_ready", s_in_ready, 1);

    // 1. ADD wrap to zero
    do_op(0, 8'hFF, 8'h01, 1'b1, "add_ff_01");
    chk("add_ff_01:const_out", s_out, 8'h00);
    chk("add_ff_01:const_c", s_carry, 1);

    // 2. SUB signed overflow, then SUB with flags held
    do_op(1, 8'h80, 8'h01, 1'b1, "sub_80_01");
    chk("sub_80_01:const_v", s_ovf, 1);
    do_op(1, 8'h01, 8'h02, 1'b0, "sub_01_02_nofi");
    chk("sub_01_02_nofi:const_out", s_out, 8'hFF);

    // Result drops once taken with nothing new
    s_out_ready = 1'b1; step();
    chk("drain:out_valid", s_out_valid, 0);

    // 3. Multiply
    do_op(8, 13, 11, 1'b1, "mul_13_11");
    chk("mul_13_11:const_out", s_out, 8'h8F);
    do_op(8, 8'h10, 8'h10, 1'b1, "mul_10_10");

    // 4. Backpressure
    s_out_ready = 1'b1; step();
    s_out_ready = 1'b0;
    s_op = 4'd0; s_a = 8'h12; s_b = 8'h34; s_fi = 1'b1; s_in_valid = 1'b1;
    step();
    model_update(0, 8'h12, 8'h34, 1'b1);
    s_op = 4'd4; s_a = 8'h0F; s_b = 8'hF0; s_fi = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp:in_ready", s_in_ready, 0);
      chk("bp:out_hold", s_out, e_out);
      chk("bp:valid_hold", s_out_valid, 1);
      step();
    end
    s_out_ready = 1'b1;
    #1;
    chk("bp:in_ready_release", s_in_ready, 1);
    step();
    s_in_valid = 1'b0;
    model_update(4, 8'h0F, 8'hF0, 1'b1);
    check_result("bp_xor");

    // 5. Reset in the middle of a multiply
    s_op = 4'd8; s_a = 8'hAB; s_b = 8'hCD; s_fi = 1'b1; s_in_valid = 1'b1;
    step();
    s_in_valid = 1'b0;
    step(); step(); step();
    #2 rst = 1'b0;
    #1;
    chk("midrst:out", s_out, 0);
    chk("midrst:out_valid", s_out_valid, 0);
    chk("midrst:flags", {s_carry, s_zero, s_neg, s_ovf}, 0);
    chk("midrst:busy", s_busy, 0);
    chk("midrst:in_ready", s_in_ready, 0);
    step();
    rst = 1'b1;
    e_out = 0; e_c = 0; e_z = 0; e_n = 0; e_v = 0;
    step();
    chk("after_rst:in_ready", s_in_ready, 1);
    chk("after_rst:busy", s_busy, 0);
    for (int i = 0; i < WIDTH + 2; i++) begin
      chk("after_rst:no_late_result", s_out_valid, 0);
      step();
    end
    do_op(0, 8'h7F, 8'h01, 1'b1, "after_rst_add");

    // 6. Shift carry and illegal opcode
    do_op(5, 8'h81, 8'h01, 1'b1, "shl_81_1");
    chk("shl_81_1:const_out", s_out, 8'h02);
    do_op(15, 8'h55, 8'h66, 1'b1, "illegal_f");
    chk("illegal_f:const_out", s_out, 8'h00);

    // Random stimulus against the model
    for (int n = 0; n < 60; n++) begin
      rop = $urandom_range(0, 10);
      if (rop > 8) rop = $urandom_range(9, 15);
      do_op(rop, $urandom_range(0, 255), $urandom_range(0, 255),
            1'($urandom_range(0, 1)), $sformatf("rnd%0d_op%0d", n, rop));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
